// File: rtl/pipe_ctrl_decoder.sv
// pipe_ctrl_decoder: ID decode plus ID/EX, EX/MEM, MEM/WB control pipeline with bubble counter.
// Optional illegal-opcode trap when ILLEGAL_TRAP_EN is defined.
module pipe_ctrl_decoder #(
  parameter int OP_W = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               valid_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               freeze_i,
  output logic               jump_id_o,
  output logic               ex_valid_o,
  output logic [ALUOP_W-1:0] ex_aluop_o,
  output logic               ex_alusrc_o,
  output logic               ex_regdst_o,
  output logic               ex_branch_o,
  output logic               ex_branchtype_o,
  output logic               mem_valid_o,
  output logic               mem_memread_o,
  output logic               mem_memwrite_o,
  output logic               mem_jal_o,
  output logic               wb_valid_o,
  output logic               wb_regwrite_o,
  output logic               wb_memtoreg_o,
  output logic               wb_jal_o,
`ifdef ILLEGAL_TRAP_EN
  output logic               illegal_o,
`endif
  output logic [CNT_W-1:0]   bubble_cnt_o
);
  localparam int B_W = ALUOP_W + 9;
  localparam logic [OP_W-1:0] OP_J = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_JAL = OP_W'(6'b001111);
  // {aluop, alusrc, regdst, branch, branchtype, memread, memwrite, regwrite, memtoreg, jal}
  logic [B_W-1:0] idCtl, exCtl;
  logic [4:0] memCtl;
  logic [2:0] wbCtl;
  logic exValid, memValid, wbValid;
  logic [CNT_W-1:0] bubbleCnt;
  logic isJ, isJal, bubble, countEn;
  always_comb begin
    idCtl = '0;
    case (instr_op_i)
      OP_W'(6'b000000): idCtl = {ALUOP_W'(3'b010), 9'b010000100};
      OP_W'(6'b010011): idCtl = {ALUOP_W'(3'b011), 9'b100000100};
      OP_W'(6'b011000): idCtl = {ALUOP_W'(3'b000), 9'b100010110};
      OP_W'(6'b101000): idCtl = {ALUOP_W'(3'b000), 9'b100001000};
      OP_W'(6'b011001): idCtl = {ALUOP_W'(3'b001), 9'b001000000};
      OP_W'(6'b011010): idCtl = {ALUOP_W'(3'b110), 9'b001100000};
      OP_W'(6'b011100): idCtl = {ALUOP_W'(3'b100), 9'b001100000};
      OP_W'(6'b011110): idCtl = {ALUOP_W'(3'b101), 9'b001100000};
      OP_W'(6'b011101): idCtl = {ALUOP_W'(3'b110), 9'b001000000};
      OP_W'(6'b001111): idCtl = {ALUOP_W'(3'b000), 9'b000000101};
      default:          idCtl = '0;
    endcase
  end
  assign isJ = instr_op_i == OP_J;
  assign isJal = instr_op_i == OP_JAL;
  assign jump_id_o = valid_i & (isJ | isJal) & ~stall_i;
`ifdef ILLEGAL_TRAP_EN
  // Every mapped opcode except j has a nonzero bundle, so that identifies legal ones.
  logic illegalId, illegalSeen;
  assign illegalId = valid_i & ~(|idCtl | isJ);
  assign bubble = stall_i | flush_i | illegalId;
  assign illegal_o = illegalId | illegalSeen;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) illegalSeen <= 1'b0;
    else if (illegalId) illegalSeen <= 1'b1;
`else
  assign bubble = stall_i | flush_i;
`endif
  assign countEn = bubble & valid_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      exValid <= 1'b0;
      exCtl <= '0;
      memValid <= 1'b0;
      memCtl <= '0;
      wbValid <= 1'b0;
      wbCtl <= '0;
      bubbleCnt <= '0;
    end else if (!freeze_i) begin
      exValid <= bubble ? 1'b0 : valid_i;
      exCtl <= bubble ? '0 : idCtl;
      memValid <= exValid;
      memCtl <= exCtl[4:0];
      wbValid <= memValid;
      wbCtl <= memCtl[2:0];
      if (countEn && bubbleCnt != '1) bubbleCnt <= bubbleCnt + CNT_W'(1);
    end
  assign ex_valid_o = exValid;
  assign ex_aluop_o = exValid ? exCtl[B_W-1:9] : '0;
  assign ex_alusrc_o = exValid & exCtl[8];
  assign ex_regdst_o = exValid & exCtl[7];
  assign ex_branch_o = exValid & exCtl[6];
  assign ex_branchtype_o = exValid & exCtl[5];
  assign mem_valid_o = memValid;
  assign mem_memread_o = memValid & memCtl[4];
  assign mem_memwrite_o = memValid & memCtl[3];
  assign mem_jal_o = memValid & memCtl[0];
  assign wb_valid_o = wbValid;
  assign wb_regwrite_o = wbValid & wbCtl[2];
  assign wb_memtoreg_o = wbValid & wbCtl[1];
  assign wb_jal_o = wbValid & wbCtl[0];
  assign bubble_cnt_o = bubbleCnt;
endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// tb_pipe_ctrl_decoder: directed-vector bench for pipe_ctrl_decoder, plus a CNT_W=2 instance for saturation.
module tb_pipe_ctrl_decoder;
  logic clk = 1'b0;
  logic rst, valid, stall, flush, freeze;
  logic [5:0] op;
  logic jump, exValid, exAluSrc, exRegDst, exBranch, exBranchType;
  logic [2:0] exAluOp;
  logic memValid, memRead, memWrite, memJal, wbValid, wbRegWrite, wbMemToReg, wbJal;
  logic [15:0] cnt;
  logic jumpB, exValidB, exAluSrcB, exRegDstB, exBranchB, exBranchTypeB;
  logic [2:0] exAluOpB;
  logic memValidB, memReadB, memWriteB, memJalB, wbValidB, wbRegWriteB, wbMemToRegB, wbJalB;
  logic [1:0] cntB;
`ifdef ILLEGAL_TRAP_EN
  logic illegal, illegalB;
`endif
  int nChecks = 0, nFails = 0;
  always #5 clk = ~clk;
  pipe_ctrl_decoder dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .valid_i(valid), .stall_i(stall),
    .flush_i(flush), .freeze_i(freeze), .jump_id_o(jump), .ex_valid_o(exValid),
    .ex_aluop_o(exAluOp), .ex_alusrc_o(exAluSrc), .ex_regdst_o(exRegDst),
    .ex_branch_o(exBranch), .ex_branchtype_o(exBranchType), .mem_valid_o(memValid),
    .mem_memread_o(memRead), .mem_memwrite_o(memWrite), .mem_jal_o(memJal),
    .wb_valid_o(wbValid), .wb_regwrite_o(wbRegWrite), .wb_memtoreg_o(wbMemToReg),
    .wb_jal_o(wbJal),
`ifdef ILLEGAL_TRAP_EN
    .illegal_o(illegal),
`endif
    .bubble_cnt_o(cnt)
  );
  pipe_ctrl_decoder #(.CNT_W(2)) dutB (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .valid_i(valid), .stall_i(stall),
    .flush_i(flush), .freeze_i(freeze), .jump_id_o(jumpB), .ex_valid_o(exValidB),
    .ex_aluop_o(exAluOpB), .ex_alusrc_o(exAluSrcB), .ex_regdst_o(exRegDstB),
    .ex_branch_o(exBranchB), .ex_branchtype_o(exBranchTypeB), .mem_valid_o(memValidB),
    .mem_memread_o(memReadB), .mem_memwrite_o(memWriteB), .mem_jal_o(memJalB),
    .wb_valid_o(wbValidB), .wb_regwrite_o(wbRegWriteB), .wb_memtoreg_o(wbMemToRegB),
    .wb_jal_o(wbJalB),
`ifdef ILLEGAL_TRAP_EN
    .illegal_o(illegalB),
`endif
    .bubble_cnt_o(cntB)
  );
  wire [7:0] exVec = {exValid, exAluOp, exAluSrc, exRegDst, exBranch, exBranchType};
  wire [3:0] memVec = {memValid, memRead, memWrite, memJal};
  wire [3:0] wbVec = {wbValid, wbRegWrite, wbMemToReg, wbJal};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // R, lw, sw, beq, jal, bne, addi
  logic [5:0] ops [7] = '{6'b000000, 6'b011000, 6'b101000, 6'b011001, 6'b001111, 6'b011010, 6'b010011};
  logic [7:0] exT [7] = '{8'b1_010_0100, 8'b1_000_1000, 8'b1_000_1000, 8'b1_001_0010, 8'b1_000_0000, 8'b1_110_0011, 8'b1_011_1000};
  logic [3:0] memT [7] = '{4'b1000, 4'b1100, 4'b1010, 4'b1000, 4'b1001, 4'b1000, 4'b1000};
  logic [3:0] wbT [7] = '{4'b1100, 4'b1110, 4'b1000, 4'b1000, 4'b1101, 4'b1000, 4'b1100};
  logic [1:0] satT [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  initial begin
    rst = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; freeze = 1'b0; op = '0;
    #2;
    check("rst_ex", exVec, 0);
    check("rst_mem", memVec, 0);
    check("rst_wb", wbVec, 0);
    check("rst_cnt", cnt, 0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      valid = i < 7;
      op = i < 7 ? ops[i] : 6'b0;
      tick;
      check($sformatf("pipe_ex%0d", i), exVec, i < 7 ? exT[i] : 8'h0);
      check($sformatf("pipe_mem%0d", i), memVec, (i >= 1 && i < 8) ? memT[i-1] : 4'h0);
      check($sformatf("pipe_wb%0d", i), wbVec, i >= 2 ? wbT[i-2] : 4'h0);
    end
    check("pipe_cnt", cnt, 0);
    valid = 1'b1; op = 6'b001111; #1;
    check("jump_jal", jump, 1);
    stall = 1'b1; #1;
    check("jump_stalled", jump, 0);
    stall = 1'b0; op = 6'b001100; #1;
    check("jump_j", jump, 1);
    valid = 1'b0; #1;
    check("jump_invalid", jump, 0);
    valid = 1'b1; op = 6'b011000;
    tick;
    check("stall_pre_ex", exVec, 8'b1_000_1000);
    op = 6'b010011; stall = 1'b1;
    tick;
    check("stall1_ex", exVec, 0);
    check("stall1_mem", memVec, 4'b1100);
    check("stall1_cnt", cnt, 1);
    tick;
    check("stall2_ex", exVec, 0);
    check("stall2_wb", wbVec, 4'b1110);
    check("stall2_cnt", cnt, 2);
    stall = 1'b0;
    tick;
    check("unstall_ex", exVec, 8'b1_011_1000);
    check("unstall_cnt", cnt, 2);
    op = 6'b011001; stall = 1'b1; freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("freeze_ex%0d", i), exVec, 8'b1_011_1000);
      check($sformatf("freeze_mem%0d", i), memVec, 0);
      check($sformatf("freeze_cnt%0d", i), cnt, 2);
    end
    freeze = 1'b0;
    tick;
    check("thaw_ex", exVec, 0);
    check("thaw_mem", memVec, 4'b1000);
    check("thaw_cnt", cnt, 3);
    stall = 1'b0; op = 6'b111111;
`ifdef ILLEGAL_TRAP_EN
    #1;
    check("illegal_id", illegal, 1);
    tick;
    check("illegal_ex", exVec, 0);
    check("illegal_cnt", cnt, 4);
    op = 6'b000000; #1;
    check("illegal_sticky", illegal, 1);
`else
    tick;
    check("unmapped_ex", exVec, 8'b1_000_0000);
    check("unmapped_cnt", cnt, 3);
`endif
    op = 6'b011000;
    tick;
    op = 6'b000000;
    tick;
    valid = 1'b0;
    check("mid_ex", exVec, 8'b1_010_0100);
    check("mid_mem", memVec, 4'b1100);
    #2 rst = 1'b1;
    #1;
    check("arst_ex", exVec, 0);
    check("arst_mem", memVec, 0);
    check("arst_wb", wbVec, 0);
    check("arst_cnt", cnt, 0);
    check("arst_cntB", cntB, 0);
`ifdef ILLEGAL_TRAP_EN
    check("arst_illegal", illegal, 0);
`endif
    tick;
    rst = 1'b0;
    flush = 1'b1; valid = 1'b1; op = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("sat_cntB%0d", i), cntB, satT[i]);
      check($sformatf("sat_cnt%0d", i), cnt, i + 1);
    end
    check("flush_ex", exVec, 0);
    flush = 1'b0; valid = 1'b0;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
